clock_face_writer: RTL and testbench
====================================

# clock_face_writer

Downstream consumer of the clock-face drawer's pixel stream; drives the 1-bit VGA framebuffer write port. After reset or a redraw request it blanks the whole screen, releases the face drawer from reset, and forwards the drawer's per-cycle x/y coordinates as foreground writes. Off-screen coordinates and immediate repeats are dropped. It stops when the drawer signals completion. It also owns the drawer's reset, so the face is always drawn onto a freshly cleared frame.

## Interface
- WIDTH, 640, screen width in pixels; legal x is 0..WIDTH-1
- HEIGHT, 480, screen height in pixels; legal y is 0..HEIGHT-1
- SETTLE, 2, cycles after the drawer is released during which its output is ignored (RAM read latency)
- FG, 1'b1, colour written for face pixels
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- src_x  in  11  drawer x coordinate, valid every cycle in DRAW
- src_y  in  11  drawer y coordinate, valid every cycle in DRAW
- src_done  in  1  drawer completion flag (clk_done)
- redraw  in  1  single-cycle request to clear and redraw
- src_reset  out  1  active-high reset to the face drawer
- x  out  11  framebuffer write x
- y  out  11  framebuffer write y
- pixel_color  out  1  framebuffer write data
- pixel_write  out  1  framebuffer write strobe
- frame_done  out  1  high while in DONE

## Operation
- FSM states: CLEAR, SETTLE, DRAW, DONE.
- CLEAR
  - Raster sweep: x increments 0..WIDTH-1, then wraps to 0 and y increments; runs y 0..HEIGHT-1.
  - One write per cycle with pixel_color=0 and pixel_write=1. src_reset=1.
  - After writing (WIDTH-1, HEIGHT-1), go to SETTLE.
- SETTLE
  - src_reset=0. pixel_write=0.
  - A down-counter loaded with SETTLE runs to 0, then the FSM goes to DRAW. SETTLE=0 goes straight to DRAW.
- DRAW
  - Each cycle, sample src_x/src_y.
  - A sample is written (x,y ← sample, pixel_color=FG, pixel_write=1) only when all of these hold:
    - src_x<WIDTH and src_y<HEIGHT;
    - the sample differs from the last coordinate written in this DRAW pass;
    - src_done=0.
  - The last-written register is invalidated on entry to DRAW, so the first in-range sample is always written.
  - src_done=1 → go to DONE. The sample on that cycle is not written.
- DONE
  - pixel_write=0, frame_done=1. src_reset stays 0, so the drawer holds its final state.
- redraw
  - Sampled in DRAW and DONE only: next state is CLEAR and src_reset=1 from the next cycle.
  - In DRAW, redraw takes priority over src_done.
  - Ignored in CLEAR and SETTLE.
- Width rule: comparisons are unsigned 11-bit. Coordinates ≥2048 are unrepresentable; no wrap handling is needed.

## Timing
- Reset (reset=0 at a clk edge): state=CLEAR, sweep counters=0, x=0, y=0, pixel_color=0, pixel_write=0, src_reset=1, frame_done=0, last-written invalid.
- First clear write (0,0) appears in the first cycle after reset is sampled high.
- CLEAR lasts exactly WIDTH*HEIGHT cycles, with pixel_write continuously high. 640×480 = 307200 cycles.
- src_reset falls on the cycle SETTLE is entered. DRAW begins SETTLE cycles later.
- DRAW latency: a sample at edge n appears on x/y/pixel_write after edge n, i.e. one registered cycle.
- x/y hold their last value whenever pixel_write=0.
- frame_done rises one cycle after src_done is sampled high in DRAW. It falls on the cycle after redraw is sampled.
- Reset asserted mid-operation overrides everything, including a simultaneous redraw; it restarts at CLEAR (0,0).

## Test plan
- Reset/clear (WIDTH=8, HEIGHT=4): release reset → 32 consecutive writes of colour 0 in raster order (0,0)…(7,3); src_reset high throughout, then low; pixel_write low for SETTLE=2 cycles.
- Forwarding: in DRAW feed (3,1),(3,1),(5,2) → exactly two writes, (3,1) then (5,2), colour 1, each one cycle after its sample.
- Clipping: feed (8,0),(0,4),(7,3) → only (7,3) written.
- Completion: feed (2,2) with src_done=1 → no write; frame_done=1 next cycle; held indefinitely with pixel_write=0.
- Redraw: redraw in DONE → next cycle src_reset=1, frame_done=0, clear restarts at (0,0). Redraw and src_done together in DRAW → CLEAR wins. Redraw during CLEAR → sweep unaffected.
- Mid-op reset: assert reset during DRAW → outputs return to reset values next cycle; clear restarts from (0,0).

Source files
------------

// File: rtl/clock_face_writer_if.sv
// Drawer-to-framebuffer bus for the clock face writer.
// master = writer side, slave = drawer/framebuffer side.
interface clock_face_writer_if;
   logic [10:0] src_x;
   logic [10:0] src_y;
   logic        src_done;
   logic        redraw;
   logic        src_reset;
   logic [10:0] x;
   logic [10:0] y;
   logic        pixel_color;
   logic        pixel_write;
   logic        frame_done;

   modport master (
      input  src_x, src_y, src_done, redraw,
      output src_reset, x, y, pixel_color, pixel_write, frame_done
   );

   modport slave (
      output src_x, src_y, src_done, redraw,
      input  src_reset, x, y, pixel_color, pixel_write, frame_done
   );
endinterface

// File: rtl/clock_face_writer.sv
// Clears the 1-bit framebuffer, releases the face drawer,
// then forwards its in-range, non-repeated pixels as writes.
module clock_face_writer #(
   parameter int   WIDTH  = 640,
   parameter int   HEIGHT = 480,
   parameter int   SETTLE = 2,
   parameter logic FG     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   clock_face_writer_if.master   bus
);

   typedef enum logic [1:0] {
      S_CLEAR, S_SETTLE, S_DRAW, S_DONE
   } state_t;

   localparam logic [10:0] XMAX  = 11'(WIDTH - 1);
   localparam logic [10:0] YMAX  = 11'(HEIGHT - 1);
   localparam logic [10:0] W     = 11'(WIDTH);
   localparam logic [10:0] H     = 11'(HEIGHT);
   localparam logic [15:0] SLOAD = (SETTLE > 0) ? 16'(SETTLE - 1) : 16'd0;

   state_t      r_state;
   state_t      w_next;
   logic [10:0] r_cx;
   logic [10:0] r_cy;
   logic [15:0] r_cnt;
   logic [10:0] r_x;
   logic [10:0] r_y;
   logic        r_color;
   logic        r_write;
   logic        r_src_reset;
   logic        r_frame_done;
   logic        r_last_vld;

   logic        w_last_px;
   logic        w_hit;
   logic        w_wr;
   logic [10:0] w_wx;
   logic [10:0] w_wy;
   logic        w_col;

   assign w_last_px = (r_cx == XMAX) && (r_cy == YMAX);

   // r_x/r_y always hold the last DRAW write while r_last_vld is set
   assign w_hit = (bus.src_x < W) && (bus.src_y < H) && !bus.src_done &&
                  !(r_last_vld && bus.src_x == r_x && bus.src_y == r_y);

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_CLEAR;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_CLEAR:
            if (w_last_px) w_next = (SETTLE == 0) ? S_DRAW : S_SETTLE;
         S_SETTLE:
            if (r_cnt == 16'd0) w_next = S_DRAW;
         S_DRAW:
            if (bus.redraw)        w_next = S_CLEAR;
            else if (bus.src_done) w_next = S_DONE;
         S_DONE:
            if (bus.redraw) w_next = S_CLEAR;
         default: w_next = S_CLEAR;
      endcase
   end

   always_comb begin
      w_wr  = 1'b0;
      w_wx  = r_cx;
      w_wy  = r_cy;
      w_col = 1'b0;
      unique case (r_state)
         S_CLEAR: w_wr = 1'b1;
         S_DRAW: begin
            if (w_hit) begin
               w_wr  = 1'b1;
               w_wx  = bus.src_x;
               w_wy  = bus.src_y;
               w_col = FG;
            end
         end
         default: w_wr = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cx         <= '0;
         r_cy         <= '0;
         r_cnt        <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_color      <= 1'b0;
         r_write      <= 1'b0;
         r_src_reset  <= 1'b1;
         r_frame_done <= 1'b0;
         r_last_vld   <= 1'b0;
      end else begin
         r_write <= w_wr;
         if (w_wr) begin
            r_x     <= w_wx;
            r_y     <= w_wy;
            r_color <= w_col;
         end
         // stays high through the last clear write, rises at once on redraw
         r_src_reset  <= (r_state == S_CLEAR) || (w_next == S_CLEAR);
         r_frame_done <= (w_next == S_DONE);
         if (r_state == S_CLEAR) begin
            if (r_cx == XMAX) begin
               r_cx <= '0;
               r_cy <= (r_cy == YMAX) ? 11'd0 : r_cy + 11'd1;
            end else begin
               r_cx <= r_cx + 11'd1;
            end
         end else begin
            r_cx <= '0;
            r_cy <= '0;
         end
         if (r_state != S_SETTLE)  r_cnt <= SLOAD;
         else if (r_cnt != 16'd0)  r_cnt <= r_cnt - 16'd1;
         if (r_state != S_DRAW)    r_last_vld <= 1'b0;
         else if (w_wr)            r_last_vld <= 1'b1;
      end
   end

   assign bus.src_reset   = r_src_reset;
   assign bus.x           = r_x;
   assign bus.y           = r_y;
   assign bus.pixel_color = r_color;
   assign bus.pixel_write = r_write;
   assign bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_clock_face_writer.sv
// Scoreboard bench for clock_face_writer on an 8x4 screen:
// expected writes (with arrival cycle) queued by the stimulus, popped by a monitor.
module tb_clock_face_writer;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int ST = 2;

   typedef struct {
      int x;
      int y;
      int c;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clock_face_writer_if bus ();

   clock_face_writer #(
      .WIDTH (W),
      .HEIGHT(H),
      .SETTLE(ST),
      .FG    (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   exp_t q[$];
   exp_t me;
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   bit m_draw;
   bit m_lv;
   int m_lx;
   int m_ly;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.pixel_write === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write act=(%0d,%0d,c%0d)@%0d exp=none",
                     bus.x, bus.y, bus.pixel_color, cyc);
         end else begin
            me = q.pop_front();
            if (bus.x !== 11'(me.x) || bus.y !== 11'(me.y) ||
                bus.pixel_color !== 1'(me.c) || cyc != me.cyc) begin
               errors++;
               $display("FAIL write act=(%0d,%0d,c%0d)@%0d exp=(%0d,%0d,c%0d)@%0d",
                        bus.x, bus.y, bus.pixel_color, cyc,
                        me.x, me.y, me.c, me.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int x, input int y, input bit d, input bit r);
      bus.src_x    = 11'(x);
      bus.src_y    = 11'(y);
      bus.src_done = d;
      bus.redraw   = r;
   endtask

   // called with the DUT in CLEAR and the sweep about to write (0,0)
   task automatic run_clear(input bit poke);
      int base;
      base   = cyc;
      m_draw = 1'b0;
      for (int k = 0; k < W * H; k++)
         q.push_back('{k % W, k / W, 0, base + 1 + k});
      for (int k = 0; k < W * H; k++) begin
         set_in($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                1'b0, poke && k == 5);
         tick();
         chk("src_reset_clear", int'(bus.src_reset), 1);
      end
      for (int k = 0; k < ST; k++) begin
         set_in($urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'b0, 1'b0);
         tick();
         chk("src_reset_settle", int'(bus.src_reset), 0);
         chk("settle_write", int'(bus.pixel_write), 0);
      end
      m_draw = 1'b1;
      m_lv   = 1'b0;
   endtask

   task automatic draw(input int x, input int y, input bit d, input bit r);
      set_in(x, y, d, r);
      if (m_draw) begin
         if (!d && x < W && y < H && !(m_lv && x == m_lx && y == m_ly)) begin
            q.push_back('{x, y, 1, cyc + 1});
            m_lv = 1'b1;
            m_lx = x;
            m_ly = y;
         end
         if (r || d) m_draw = 1'b0;
      end
      tick();
   endtask

   task automatic rand_draw(input int n);
      int px;
      int py;
      px = 0;
      py = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0 || $urandom_range(0, 2) != 0) begin
            px = $urandom_range(0, W + 1);
            py = $urandom_range(0, H + 1);
         end
         draw(px, py, 1'b0, 1'b0);
      end
   endtask

   task automatic chk_reset_vals(input string n);
      chk({n, "_src_reset"}, int'(bus.src_reset), 1);
      chk({n, "_pixel_write"}, int'(bus.pixel_write), 0);
      chk({n, "_frame_done"}, int'(bus.frame_done), 0);
      chk({n, "_x"}, int'(bus.x), 0);
      chk({n, "_y"}, int'(bus.y), 0);
      chk({n, "_color"}, int'(bus.pixel_color), 0);
   endtask

   initial begin
      m_draw = 1'b0;
      m_lv   = 1'b0;
      m_lx   = 0;
      m_ly   = 0;
      reset  = 1'b0;
      set_in(0, 0, 1'b0, 1'b0);
      repeat (3) tick();
      chk_reset_vals("reset");
      reset = 1'b1;
      run_clear(1'b0);

      draw(3, 1, 1'b0, 1'b0);
      draw(3, 1, 1'b0, 1'b0);
      draw(5, 2, 1'b0, 1'b0);
      draw(8, 0, 1'b0, 1'b0);
      draw(0, 4, 1'b0, 1'b0);
      draw(7, 3, 1'b0, 1'b0);
      rand_draw(30);

      draw(2, 2, 1'b1, 1'b0);
      chk("frame_done_rise", int'(bus.frame_done), 1);
      repeat (5) begin
         draw($urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'b1, 1'b0);
         chk("frame_done_hold", int'(bus.frame_done), 1);
         chk("src_reset_done", int'(bus.src_reset), 0);
         chk("x_hold", int'(bus.x), m_lx);
         chk("y_hold", int'(bus.y), m_ly);
      end

      draw(0, 0, 1'b1, 1'b1);
      chk("redraw_src_reset", int'(bus.src_reset), 1);
      chk("redraw_frame_done", int'(bus.frame_done), 0);
      run_clear(1'b1);

      rand_draw(10);
      draw(4, 1, 1'b1, 1'b1);
      chk("both_frame_done", int'(bus.frame_done), 0);
      chk("both_src_reset", int'(bus.src_reset), 1);
      run_clear(1'b0);

      rand_draw(10);
      reset  = 1'b0;
      m_draw = 1'b0;
      set_in(1, 1, 1'b0, 1'b1);
      tick();
      chk_reset_vals("midreset");
      reset = 1'b1;
      set_in(0, 0, 1'b0, 1'b0);
      run_clear(1'b0);

      rand_draw(8);
      draw(0, 0, 1'b1, 1'b0);
      chk("final_frame_done", int'(bus.frame_done), 1);
      tick();
      tick();
      chk("queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
